cmd_sequencer: RTL

//  Command controller for the serial_comm transceiver. Accepts 24-bit commands (cmd/cmd_rdy),

---
 rtl/cmd_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: command controller for the serial_comm transceiver.
// Decodes 24-bit commands, runs the pressure-sensor sample handshake or
// offset register access, applies offset correction and drives the
// 16-bit reply (tx_data/trmt). Holds one pending command.
// Ports: clk, rst (sync, active-high); cmd/cmd_rdy in; tx_done in;
//        tx_data/trmt out; smpl_req out, smpl_vld/raw_press in;
//        offset, busy, overrun (sticky) out.
// Optional feature: define CMD_ACK_EN to make WR_OFF send a 16'hA5A5 ack.
module cmd_sequencer #(
    parameter int          TIMEOUT_CYC = 1023,
    parameter logic [15:0] ERR_WORD    = 16'hDEAD,
    parameter logic [15:0] BAD_WORD    = 16'hBAD0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] cmd,
    input  logic        cmd_rdy,
    input  logic        tx_done,
    output logic [15:0] tx_data,
    output logic        trmt,
    output logic        smpl_req,
    input  logic        smpl_vld,
    input  logic [15:0] raw_press,
    output logic [15:0] offset,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    localparam logic [7:0] OP_READ_P = 8'h01;
    localparam logic [7:0] OP_WR_OFF = 8'h02;
    localparam logic [7:0] OP_RD_OFF = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SAMPLE,
        SEND,
        WAIT_TX
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic          trmt_q, trmt_d;
    logic          smpl_req_q, smpl_req_d;
    logic [15:0]   offset_q, offset_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic [23:0]   cur_q, cur_d;
    logic [23:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Raw reading is unsigned, offset signed: widen to 18 bits so the
    // sum can neither wrap below zero nor above 16'hFFFF.
    logic [17:0] sum;
    logic [15:0] corrected;

    always_comb begin
        sum = {2'b00, raw_press} + {{2{offset_q[15]}}, offset_q};
        if (sum[17]) begin
            corrected = 16'h0000;
        end else if (sum[16]) begin
            corrected = 16'hFFFF;
        end else begin
            corrected = sum[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        offset_d   = offset_q;
        ovr_d      = ovr_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;

        // While busy a new command fills the slot or is lost.
        if (state_q != IDLE && cmd_rdy) begin
            if (!pend_vld_q) begin
                pend_d     = cmd;
                pend_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    // Pending command first; a simultaneous new
                    // command takes over the freed slot.
                    cur_d      = pend_q;
                    state_d    = DECODE;
                    pend_d     = cmd;
                    pend_vld_d = cmd_rdy;
                end else if (cmd_rdy) begin
                    cur_d   = cmd;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (cur_q[23:16])
                    OP_READ_P: begin
                        cnt_d   = '0;
                        state_d = SAMPLE;
                    end
                    OP_WR_OFF: begin
                        offset_d = cur_q[15:0];
`ifdef CMD_ACK_EN
                        tx_data_d = 16'hA5A5;
                        state_d   = SEND;
`else
                        state_d = IDLE;
`endif
                    end
                    OP_RD_OFF: begin
                        tx_data_d = offset_q;
                        state_d   = SEND;
                    end
                    default: begin
                        tx_data_d = BAD_WORD;
                        state_d   = SEND;
                    end
                endcase
            end
            SAMPLE: begin
                if (smpl_vld) begin
                    tx_data_d = corrected;
                    cnt_d     = '0;
                    state_d   = SEND;
                end else if (cnt_q == CNT_MAX) begin
                    tx_data_d = ERR_WORD;
                    cnt_d     = '0;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                trmt_d  = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        smpl_req_d = (state_d == SAMPLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            trmt_q     <= 1'b0;
            smpl_req_q <= 1'b0;
            offset_q   <= '0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
            smpl_req_q <= smpl_req_d;
            offset_q   <= offset_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign trmt     = trmt_q;
    assign smpl_req = smpl_req_q;
    assign offset   = offset_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule
